// File: rtl/hdmi_cfg_sequencer.sv
// Frame-aligned configuration master for the 720p sync/pattern generator control port.
// Mode/gamma writes and gamma LUT streaming are deferred to vsync onset; optional pattern auto-cycle.
module hdmi_cfg_sequencer #(
  parameter int LUT_DEPTH = 256,
  parameter int NUM_MODES = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync_in,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_arg,
  output logic        tbl_rd,
  output logic [7:0]  tbl_addr,
  input  logic [7:0]  tbl_data,
  output logic [1:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic        busy,
  output logic [2:0]  cur_mode,
  output logic        cur_gamma,
  output logic [3:0]  state_dbg
);

  // Command handshake: a command transfers on any cycle where cmd_valid and cmd_ready are both
  // high; cmd_ready is high only in IDLE outside reset, and the offered command must stay stable
  // while cmd_valid is high and cmd_ready is low.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_VS   = 4'd1,
    S_W_MODE    = 4'd2,
    S_W_GAMMA   = 4'd3,
    S_L_DIS     = 4'd4,
    S_L_ADDR    = 4'd5,
    S_L_DATA    = 4'd6,
    S_L_RESTORE = 4'd7,
    S_AUTO      = 4'd8
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(LUT_DEPTH - 1);

  state_t     state, state_nxt;
  logic       vs_d;
  logic       vs_rise;
  logic [1:0] op_q;
  logic [2:0] arg_q;
  logic [7:0] idx;
  logic [7:0] auto_n;
  logic [7:0] frame_cnt;
  logic       idle_accept;
  logic       auto_tick;
  logic       auto_hit;
  logic [2:0] next_mode;

  assign vs_rise     = vsync_in & ~vs_d;
  assign idle_accept = (state == S_IDLE) & cmd_valid & ~reset;
  // A frame only counts toward auto-cycle while nothing else wants the bus.
  assign auto_tick   = (state == S_IDLE) && (auto_n != 8'd0) && vs_rise && !idle_accept;
  assign auto_hit    = auto_tick && (({1'b0, frame_cnt} + 9'd1) == {1'b0, auto_n});
  assign next_mode   = 3'(({1'b0, cur_mode} + 4'd1) % 4'(NUM_MODES));
  assign state_dbg   = state;

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    m_write     = 1'b0;
    m_address   = 2'd0;
    m_writedata = 32'd0;
    tbl_rd      = 1'b0;
    tbl_addr    = 8'd0;
    case (state)
      S_IDLE: begin
        cmd_ready = ~reset;
        busy      = 1'b0;
        if (idle_accept && cmd_op != 2'd3) state_nxt = S_WAIT_VS;
        else if (auto_hit)                 state_nxt = S_AUTO;
      end
      S_WAIT_VS: begin
        if (vs_rise) begin
          case (op_q)
            2'd0:    state_nxt = S_W_MODE;
            2'd1:    state_nxt = S_W_GAMMA;
            default: state_nxt = S_L_DIS;
          endcase
        end
      end
      S_W_MODE: begin
        m_write     = 1'b1;
        m_address   = 2'd0;
        m_writedata = {29'd0, arg_q};
        state_nxt   = S_IDLE;
      end
      S_W_GAMMA: begin
        m_write     = 1'b1;
        m_address   = 2'd1;
        m_writedata = {31'd0, arg_q[0]};
        state_nxt   = S_IDLE;
      end
      S_L_DIS: begin
        m_write   = 1'b1;
        m_address = 2'd1;
        state_nxt = S_L_ADDR;
      end
      S_L_ADDR: begin
        m_write     = 1'b1;
        m_address   = 2'd2;
        m_writedata = {24'd0, idx};
        tbl_rd      = 1'b1;
        tbl_addr    = idx;
        state_nxt   = S_L_DATA;
      end
      S_L_DATA: begin
        // Table returns data one cycle after the read strobe issued in L_ADDR.
        m_write     = 1'b1;
        m_address   = 2'd3;
        m_writedata = {24'd0, tbl_data};
        state_nxt   = (idx == LAST_IDX) ? S_L_RESTORE : S_L_ADDR;
      end
      S_L_RESTORE: begin
        m_write     = 1'b1;
        m_address   = 2'd1;
        m_writedata = {31'd0, cur_gamma};
        state_nxt   = S_IDLE;
      end
      S_AUTO: begin
        busy        = 1'b0;
        m_write     = 1'b1;
        m_address   = 2'd0;
        m_writedata = {29'd0, next_mode};
        state_nxt   = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      vs_d      <= 1'b0;
      op_q      <= 2'd0;
      arg_q     <= 3'd0;
      idx       <= 8'd0;
      auto_n    <= 8'd0;
      frame_cnt <= 8'd0;
      cur_mode  <= 3'd0;
      cur_gamma <= 1'b0;
    end else begin
      state <= state_nxt;
      vs_d  <= vsync_in;
      if (idle_accept) begin
        if (cmd_op == 2'd3) begin
          auto_n    <= cmd_arg;
          frame_cnt <= 8'd0;
        end else begin
          op_q  <= cmd_op;
          arg_q <= cmd_arg[2:0];
        end
      end
      if (auto_tick) frame_cnt <= auto_hit ? 8'd0 : frame_cnt + 8'd1;
      case (state)
        S_W_MODE: begin
          cur_mode <= arg_q;
          auto_n   <= 8'd0;
        end
        S_W_GAMMA: cur_gamma <= arg_q[0];
        S_L_DIS:   idx       <= 8'd0;
        S_L_DATA:  idx       <= idx + 8'd1;
        S_AUTO:    cur_mode  <= next_mode;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hdmi_cfg_sequencer.md
# hdmi_cfg_sequencer

Frame-aligned configuration controller for the 720p HDMI sync/pattern generator. It drives the generator's 2-bit Avalon-MM control slave as a write-only master. It applies mode and gamma changes only at vertical-sync onset, and streams a 256-entry gamma LUT from an external table memory without visible tearing. It can also auto-cycle test patterns every N frames. It sits between the host command source and the generator's control port; the host no longer writes the generator directly.

## Interface
- `LUT_DEPTH`, 256: gamma LUT entries loaded per load command.
- `NUM_MODES`, 7: pattern modes visited by auto-cycle (0..NUM_MODES-1).
- `clk`  in  1  pixel clock, 74.25 MHz; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `vsync_in`  in  1  generator `hdmi_vs`, same clock domain, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  opcodes:
  - 0 set mode (`cmd_arg[2:0]`)
  - 1 set gamma enable (`cmd_arg[0]`)
  - 2 load LUT
  - 3 auto-cycle period (`cmd_arg`, 0 = off)
- `cmd_arg`  in  8  command argument.
- `tbl_rd`  out  1  table read strobe.
- `tbl_addr`  out  8  table read address.
- `tbl_data`  in  8  table data, valid the cycle after `tbl_rd`.
- `m_address`  out  2  generator control address:
  - 0 mode
  - 1 gamma ctrl
  - 2 LUT addr
  - 3 LUT data
- `m_write`  out  1  write strobe; the slave never stalls.
- `m_writedata`  out  32  write data; upper bits are zero.
- `busy`  out  1  a command is pending or executing.
- `cur_mode`  out  3  last mode written.
- `cur_gamma`  out  1  last gamma enable written.

## Operation
- Frame edge: `vs_d` registers `vsync_in`; `vs_rise = vsync_in & ~vs_d`. All generator writes are triggered by `vs_rise`.
- FSM states: IDLE, WAIT_VS, W_MODE, W_GAMMA, L_DIS, L_ADDR, L_DATA, L_RESTORE, AUTO.
- IDLE: `cmd_ready`=1.
  - On accept of op 0/1/2, the command is latched and the FSM moves to WAIT_VS.
  - Op 3 completes in place with no write: `auto_n`←`cmd_arg`, frame counter←0.
- WAIT_VS: on `vs_rise`, go to W_MODE (op 0), W_GAMMA (op 1) or L_DIS (op 2).
- W_MODE: one write to addr 0 with `arg[2:0]`; update `cur_mode`; disable auto-cycle (`auto_n`←0); return to IDLE.
- W_GAMMA: one write to addr 1 with `arg[0]`; update `cur_gamma`; return to IDLE.
- LUT load, in order:
  - L_DIS: write addr 1 = 0.
  - Per entry i = 0..LUT_DEPTH-1:
    - L_ADDR: write addr 2 = i, with `tbl_rd`=1 and `tbl_addr`=i in the same cycle.
    - L_DATA (next cycle): write addr 3 = `tbl_data`.
  - L_RESTORE: write addr 1 = `cur_gamma`; return to IDLE.
  - Address and data writes are never issued in the same cycle.
- Auto-cycle: active when `auto_n`≠0 and the FSM is in IDLE.
  - Every `vs_rise` increments the frame counter.
  - When the counter reaches `auto_n`, the counter←0 and the FSM enters AUTO: one write to addr 0 with (`cur_mode`+1) mod NUM_MODES; update `cur_mode`.
  - Mode 7 is never produced.
- Priority: if a command is pending in WAIT_VS, `vs_rise` serves the command. The auto frame counter does not advance on that frame.
- `vs_rise` while the FSM is busy in any write state is ignored.
- Reset mid-load: the FSM returns to IDLE immediately, with no restore write.
  - `cur_mode`←0, `cur_gamma`←0, `auto_n`←0.
  - This matches the generator's own reset defaults.

## Timing
- Reset values:
  - `cmd_ready`=0 during reset, 1 from the first cycle after reset.
  - `busy`=0, `m_write`=0, `m_address`=0, `m_writedata`=0.
  - `tbl_rd`=0, `tbl_addr`=0, `cur_mode`=0, `cur_gamma`=0.
- Let `vsync_in` first be seen high at cycle V (`vs_rise` in V). The first write for the pending command is issued at V+1.
- Set mode / set gamma: write at V+1; IDLE and `cmd_ready`=1 at V+2.
- LUT load:
  - Disable write at V+1.
  - Entry i: addr write at V+2+2i, data write at V+3+2i.
  - Last data write at V+513; restore write at V+514; `cmd_ready`=1 at V+515.
  - The 515 cycles fit well within the 30-line vertical blank (49,500 cycles).
- `busy`: high from the cycle after accept until the cycle the final write is issued, inclusive.
- Auto step: write at V+1 of the qualifying frame.

## Test plan
- Accept op0 arg=4 mid-frame -> no write before `vs_rise`; single write (addr 0, data 4) at V+1; `cur_mode`=4.
- Op2 with table[i]=255-i -> at V+1 write addr 1 = 0; 512 alternating addr-2/addr-3 writes, with data for entry 10 = 245; restore addr 1 = `cur_gamma` at V+514; no other writes.
- Op3 arg=2 with `cur_mode`=5 -> mode writes 6, 0, 1 on every 2nd `vs_rise`.
- Auto-cycle active, op1 arg=1 pending at a qualifying frame -> only the gamma write on that frame; the auto step moves out by one frame.
- Assert `reset` at V+100 during a LUT load -> outputs at reset values the next cycle; no restore write; `cmd_ready`=1 after reset release.
- `vsync_in` held high for 5 lines -> exactly one `vs_rise` and one command execution per frame.
